// File: rtl/password_pkg.sv
// Shared key codes and FSM state encoding for the keypad password sequencer.
package password_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BS    = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_CHG   = 4'hD;

  typedef enum logic [2:0] {
    StEntry,
    StCheck,
    StOpen,
    StSetNew,
    StLockout
  } state_e;

  // Codes 0-9 are digits; everything above is a command or unused.
  function automatic logic is_digit(logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_buf.sv
// Shift buffer for typed digits: newest digit in the LS nibble, with a digit count.
module digit_buf
  import password_pkg::*;
#(
  parameter int unsigned PW_LEN = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [3:0]            digit_i,
  output logic [4*PW_LEN-1:0]   buf_o,
  output logic [3:0]            cnt_o
);

  localparam logic [3:0] CntMax = 4'(PW_LEN);

  logic [4*PW_LEN-1:0] buf_q, buf_d;
  logic [3:0]          cnt_q, cnt_d;

  // Clear beats push beats pop; push on a full buffer and pop on an empty one are dropped.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (push_i && (cnt_q < CntMax)) begin
      buf_d      = buf_q << 4;
      buf_d[3:0] = digit_i;
      cnt_d      = cnt_q + 4'd1;
    end else if (pop_i && (cnt_q != 4'd0)) begin
      buf_d = buf_q >> 4;
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Buffer and count registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buf_o = buf_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/password_ctrl.sv
// Keypad password sequencer: collects digits, checks them against the stored password,
// drives the lock, counts failures into a timed lockout and supports password change.
module password_ctrl
  import password_pkg::*;
#(
  parameter int unsigned         PW_LEN   = 4,
  parameter logic [4*PW_LEN-1:0] INIT_PW  = 16'h1234,
  parameter int unsigned         MAX_FAIL = 3,
  parameter int unsigned         OPEN_CYC = 500_000_000,
  parameter int unsigned         LOCK_CYC = 1_000_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_en,
  input  logic [3:0]          key_val,
  output logic                unlocked,
  output logic                alarm,
  output logic                err_pulse,
  output logic                saved,
  output logic [3:0]          entry_cnt,
  output logic [4*PW_LEN-1:0] entry_buf,
  output logic [1:0]          LED
);

  localparam int unsigned TMax   = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int unsigned TW     = $clog2(TMax + 1);
  localparam int unsigned FW     = $clog2(MAX_FAIL + 1);
  localparam logic [3:0]  CntMax = 4'(PW_LEN);

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [FW-1:0]       fail_q, fail_d, fail_inc;
  logic [4*PW_LEN-1:0] pw_q, pw_d;
  logic                err_ev, err_ev_q, saved_ev;
  logic                unlocked_q, alarm_q, err_pulse_q, saved_q;
  logic                buf_clr, buf_push, buf_pop;
  logic [4*PW_LEN-1:0] dbuf;
  logic [3:0]          dcnt;
  logic                full, empty, match, timer_end;

  digit_buf #(
    .PW_LEN (PW_LEN)
  ) u_digit_buf (
    .clk_i    (clk),
    .reset_ni (reset),
    .clr_i    (buf_clr),
    .push_i   (buf_push),
    .pop_i    (buf_pop),
    .digit_i  (key_val),
    .buf_o    (dbuf),
    .cnt_o    (dcnt)
  );

  assign full      = (dcnt == CntMax);
  assign empty     = (dcnt == 4'd0);
  assign match     = (dbuf == pw_q);
  // Timer expires on the idle cycle that would take it from 1 to 0.
  assign timer_end = (timer_q <= TW'(1));
  assign fail_inc  = (fail_q >= FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StEntry;
    else        state_q <= state_d;
  end

  // Next-state logic; a key strobe in OPEN takes priority over timer expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEntry: begin
        if (key_en && (key_val == KEY_ENTER) && full) state_d = StCheck;
      end
      StCheck: begin
        if (match)                         state_d = StOpen;
        else if (fail_inc >= FW'(MAX_FAIL)) state_d = StLockout;
        else                               state_d = StEntry;
      end
      StOpen: begin
        if (key_en) begin
          if (key_val == KEY_CLR)      state_d = StEntry;
          else if (key_val == KEY_CHG) state_d = StSetNew;
        end else if (timer_end) begin
          state_d = StEntry;
        end
      end
      StSetNew: begin
        if (key_en) begin
          if ((key_val == KEY_CLR) && empty)        state_d = StOpen;
          else if ((key_val == KEY_ENTER) && full) state_d = StOpen;
        end
      end
      StLockout: begin
        if (timer_end) state_d = StEntry;
      end
      default: state_d = StEntry;
    endcase
  end

  // Datapath controls: digit buffer, timer, fail counter, password and event strobes.
  always_comb begin
    buf_clr  = 1'b0;
    buf_push = 1'b0;
    buf_pop  = 1'b0;
    timer_d  = timer_q;
    fail_d   = fail_q;
    pw_d     = pw_q;
    err_ev   = 1'b0;
    saved_ev = 1'b0;
    unique case (state_q)
      StEntry, StSetNew: begin
        if (key_en) begin
          buf_push = is_digit(key_val);
          buf_pop  = (key_val == KEY_BS);
          buf_clr  = (key_val == KEY_CLR);
          if (state_q == StSetNew) begin
            if ((key_val == KEY_ENTER) && full) begin
              pw_d     = dbuf;
              saved_ev = 1'b1;
              buf_clr  = 1'b1;
              timer_d  = TW'(OPEN_CYC);
            end else if ((key_val == KEY_CLR) && empty) begin
              timer_d = TW'(OPEN_CYC);
            end
          end
        end
      end
      StCheck: begin
        buf_clr = 1'b1;
        if (match) begin
          fail_d  = '0;
          timer_d = TW'(OPEN_CYC);
        end else begin
          err_ev = 1'b1;
          fail_d = fail_inc;
          if (fail_inc >= FW'(MAX_FAIL)) timer_d = TW'(LOCK_CYC);
        end
      end
      StOpen: begin
        if (key_en) begin
          timer_d = TW'(OPEN_CYC);
          buf_clr = (key_val == KEY_CHG);
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end
      end
      StLockout: begin
        if (timer_end) begin
          timer_d = '0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q  <= '0;
      fail_q   <= '0;
      pw_q     <= INIT_PW;
      err_ev_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      pw_q     <= pw_d;
      err_ev_q <= err_ev;
    end
  end

  // Output registers; err_pulse is staged once more so it lines up with unlocked/alarm.
  always_ff @(posedge clk) begin
    if (!reset) begin
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      saved_q     <= 1'b0;
    end else begin
      unlocked_q  <= (state_q == StOpen) || (state_q == StSetNew);
      alarm_q     <= (state_q == StLockout);
      err_pulse_q <= err_ev_q;
      saved_q     <= saved_ev;
    end
  end

  assign unlocked  = unlocked_q;
  assign alarm     = alarm_q;
  assign err_pulse = err_pulse_q;
  assign saved     = saved_q;
  assign entry_cnt = dcnt;
  assign entry_buf = dbuf;
  assign LED       = {alarm_q, unlocked_q};

endmodule

// File: tb/tb_password_ctrl.sv
// Directed bench for password_ctrl with short open/lockout timers.
module tb_password_ctrl;

  logic        clk;
  logic        reset;
  logic        key_en;
  logic [3:0]  key_val;
  logic        unlocked, alarm, err_pulse, saved;
  logic [3:0]  entry_cnt;
  logic [15:0] entry_buf;
  logic [1:0]  LED;

  int n_vec = 0;
  int n_err = 0;

  password_ctrl #(
    .PW_LEN   (4),
    .INIT_PW  (16'h1234),
    .MAX_FAIL (3),
    .OPEN_CYC (20),
    .LOCK_CYC (30)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_en    (key_en),
    .key_val   (key_val),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .err_pulse (err_pulse),
    .saved     (saved),
    .entry_cnt (entry_cnt),
    .entry_buf (entry_buf),
    .LED       (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_en  = 1'b1;
    key_val = k;
    @(posedge clk);
    #1;
    key_en  = 1'b0;
    key_val = 4'h0;
  endtask

  task automatic enter(input logic [15:0] pw);
    for (int i = 3; i >= 0; i--) press(pw[i*4 +: 4]);
    press(4'hA);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".unlocked"}, unlocked, 0);
    check({tag, ".alarm"}, alarm, 0);
    check({tag, ".err"}, err_pulse, 0);
    check({tag, ".saved"}, saved, 0);
    check({tag, ".cnt"}, entry_cnt, 0);
    check({tag, ".buf"}, entry_buf, 0);
    check({tag, ".led"}, LED, 0);
  endtask

  initial begin
    reset   = 1'b0;
    key_en  = 1'b0;
    key_val = 4'h0;
    tick(2);
    check_idle("reset");
    reset = 1'b1;
    tick();

    // 1: correct password, unlocked two cycles after A
    enter(16'h1234);
    tick();
    check("t1.unl_early", unlocked, 0);
    tick();
    check("t1.unl", unlocked, 1);
    check("t1.led", LED, 2'b01);
    check("t1.cnt", entry_cnt, 0);
    press(4'hC);
    tick();
    check("t1.relock", unlocked, 0);

    // 2: three wrong entries into lockout
    enter(16'h1235);
    tick(2);
    check("t2.err1", err_pulse, 1);
    check("t2.alarm1", alarm, 0);
    tick();
    check("t2.err1_end", err_pulse, 0);
    enter(16'h1235);
    tick(2);
    check("t2.err2", err_pulse, 1);
    enter(16'h1235);
    tick();
    check("t2.alarm_early", alarm, 0);
    tick();
    check("t2.err3", err_pulse, 1);
    check("t2.alarm", alarm, 1);
    check("t2.led", LED, 2'b10);
    enter(16'h1234);
    check("t2.lock_cnt", entry_cnt, 0);
    check("t2.lock_unl", unlocked, 0);
    tick(24);
    check("t2.alarm_last", alarm, 1);
    tick();
    check("t2.alarm_off", alarm, 0);
    enter(16'h1234);
    tick(2);
    check("t2.unl_after", unlocked, 1);
    press(4'hC);
    tick();

    // 3: backspace, overflow digit dropped, short entry ignored
    press(4'h1);
    press(4'h2);
    press(4'h9);
    check("t3.buf129", entry_buf, 16'h0129);
    press(4'hB);
    check("t3.bs_buf", entry_buf, 16'h0012);
    check("t3.bs_cnt", entry_cnt, 2);
    press(4'h3);
    press(4'h4);
    press(4'h5);
    check("t3.full_buf", entry_buf, 16'h1234);
    check("t3.full_cnt", entry_cnt, 4);
    press(4'hA);
    tick(2);
    check("t3.unl", unlocked, 1);
    press(4'hC);
    tick();
    check("t3.relock", unlocked, 0);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'hA);
    tick(2);
    check("t3.short_err", err_pulse, 0);
    check("t3.short_unl", unlocked, 0);
    check("t3.short_cnt", entry_cnt, 3);
    press(4'hC);
    check("t3.clr_cnt", entry_cnt, 0);

    // 4: password change while open
    enter(16'h1234);
    tick(2);
    check("t4.unl", unlocked, 1);
    press(4'hD);
    press(4'h9);
    press(4'h8);
    press(4'h7);
    press(4'h6);
    check("t4.new_buf", entry_buf, 16'h9876);
    check("t4.setnew_unl", unlocked, 1);
    press(4'hA);
    check("t4.saved", saved, 1);
    check("t4.saved_unl", unlocked, 1);
    tick();
    check("t4.saved_end", saved, 0);
    check("t4.after_unl", unlocked, 1);
    check("t4.after_cnt", entry_cnt, 0);
    press(4'hC);
    tick();
    check("t4.relock", unlocked, 0);
    enter(16'h1234);
    tick(2);
    check("t4.old_err", err_pulse, 1);
    check("t4.old_unl", unlocked, 0);
    tick();
    enter(16'h9876);
    tick(2);
    check("t4.new_unl", unlocked, 1);
    press(4'hC);
    tick();

    // 5: auto-relock after 20 idle cycles, key reloads the timer
    enter(16'h9876);
    tick(21);
    check("t5.open_last", unlocked, 1);
    tick();
    check("t5.relock", unlocked, 0);
    enter(16'h9876);
    tick(18);
    press(4'h5);
    tick(20);
    check("t5.reload_open", unlocked, 1);
    tick();
    check("t5.reload_relock", unlocked, 0);

    // 6: reset during lockout and after a password change
    for (int i = 0; i < 3; i++) begin
      enter(16'h1235);
      tick(2);
    end
    check("t6.in_lock", alarm, 1);
    reset = 1'b0;
    tick();
    check_idle("t6.rst1");
    reset = 1'b1;
    enter(16'h9876);
    tick(2);
    check("t6.changed_pw_lost", err_pulse, 1);
    tick();
    enter(16'h1234);
    tick(2);
    check("t6.init_unl", unlocked, 1);
    press(4'hD);
    enter(16'h5555);
    check("t6.saved", saved, 1);
    reset = 1'b0;
    tick();
    check_idle("t6.rst2");
    reset = 1'b1;
    enter(16'h5555);
    tick(2);
    check("t6.new_lost", err_pulse, 1);
    tick();
    enter(16'h1234);
    tick(2);
    check("t6.final_unl", unlocked, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
